// File: rtl/plic_gateway_arb.sv
// PLIC interrupt core: per-source level gateways feeding a registered
// priority arbiter that drives the hart's external interrupt and claim id.
module plic_gateway_arb #(
    parameter int IRQ_NUM  = 21,
    parameter int IRQ_WID  = 5,
    parameter int PRIO_WID = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic [IRQ_NUM-1:0]           irq_src_i,
    input  logic [IRQ_NUM*PRIO_WID-1:0]  prio_i,
    input  logic [IRQ_NUM-1:0]           ie_i,
    input  logic [PRIO_WID-1:0]          thold_i,
    input  logic                         claim_i,
    input  logic                         complete_i,
    input  logic [IRQ_WID-1:0]           complete_id_i,
    output logic [IRQ_NUM-1:0]           ip_o,
    output logic [IRQ_WID-1:0]           claim_id_o,
    output logic                         ext_irq_o
);

    typedef enum logic [1:0] {
        GW_IDLE = 2'd0,
        GW_PEND = 2'd1,
        GW_INFL = 2'd2
    } gw_state_t;

    gw_state_t gw_q [IRQ_NUM];
    gw_state_t gw_d [IRQ_NUM];

    logic [IRQ_WID-1:0]  win_id;
    logic [PRIO_WID-1:0] win_prio;

    logic [IRQ_WID-1:0]  win_id_p1;
    logic [PRIO_WID-1:0] win_prio_p1;
    logic [PRIO_WID-1:0] thold_p1;
    logic                vld_p1;

    logic claim_fire;

    // Source 0 is reserved and its priority slot is never arbitrated.
    logic unused_bits;
    assign unused_bits = ^{irq_src_i[0], ie_i[0], prio_i[PRIO_WID-1:0]};

    // A read only claims when an interrupt is actually being presented.
    assign claim_fire = claim_i & vld_p1;

    always_comb begin
        for (int i = 0; i < IRQ_NUM; i++) begin
            gw_d[i] = gw_q[i];
        end
        for (int i = 1; i < IRQ_NUM; i++) begin
            case (gw_q[i])
                GW_IDLE: begin
                    if (irq_src_i[i]) gw_d[i] = GW_PEND;
                end
                GW_PEND: begin
                    if (claim_fire && (win_id_p1 == IRQ_WID'(i))) gw_d[i] = GW_INFL;
                end
                GW_INFL: begin
                    // Out-of-range and zero ids match no gateway and fall through.
                    if (complete_i && (complete_id_i == IRQ_WID'(i))) gw_d[i] = GW_IDLE;
                end
                default: gw_d[i] = GW_IDLE;
            endcase
        end
        gw_d[0] = GW_IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < IRQ_NUM; i++) begin
                gw_q[i] <= GW_IDLE;
            end
        end else begin
            for (int i = 0; i < IRQ_NUM; i++) begin
                gw_q[i] <= gw_d[i];
            end
        end
    end

    always_comb begin
        ip_o = '0;
        for (int i = 1; i < IRQ_NUM; i++) begin
            ip_o[i] = (gw_q[i] == GW_PEND);
        end
    end

    // Strict greater-than keeps the lowest id on a priority tie; a zero
    // priority can never beat the initial zero and so never wins.
    always_comb begin
        win_id   = '0;
        win_prio = '0;
        for (int i = 1; i < IRQ_NUM; i++) begin
            if (ip_o[i] && ie_i[i] && (prio_i[i*PRIO_WID +: PRIO_WID] > win_prio)) begin
                win_prio = prio_i[i*PRIO_WID +: PRIO_WID];
                win_id   = IRQ_WID'(i);
            end
        end
    end

    // ---- stage p1: registered winner, threshold and presentation ----
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            win_id_p1   <= '0;
            win_prio_p1 <= '0;
            thold_p1    <= '0;
            vld_p1      <= 1'b0;
        end else begin
            thold_p1 <= thold_i;
            if (claim_fire) begin
                // One-cycle bubble so the just-claimed id cannot be offered again.
                win_id_p1   <= '0;
                win_prio_p1 <= '0;
                vld_p1      <= 1'b0;
            end else begin
                win_id_p1   <= win_id;
                win_prio_p1 <= win_prio;
                vld_p1      <= (win_prio > thold_i);
            end
        end
    end

    assign ext_irq_o  = vld_p1;
    assign claim_id_o = vld_p1 ? win_id_p1 : '0;

endmodule

// File: tb/tb_plic_gateway_arb.sv
// Bench for plic_gateway_arb: directed vector table, hand-written reset
// sequence, then randomized traffic against a behavioural model.
module tb_plic_gateway_arb;

    localparam int IRQ_NUM  = 21;
    localparam int IRQ_WID  = 5;
    localparam int PRIO_WID = 4;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic [IRQ_NUM-1:0]          irq_src;
    logic [IRQ_NUM*PRIO_WID-1:0] prio;
    logic [IRQ_NUM-1:0]          ie;
    logic [PRIO_WID-1:0]         thold;
    logic                        claim;
    logic                        complete;
    logic [IRQ_WID-1:0]          cid;
    logic [IRQ_NUM-1:0]          ip;
    logic [IRQ_WID-1:0]          claim_id;
    logic                        ext_irq;

    always #5 clk = ~clk;

    plic_gateway_arb #(.IRQ_NUM(IRQ_NUM), .IRQ_WID(IRQ_WID), .PRIO_WID(PRIO_WID)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .irq_src_i     (irq_src),
        .prio_i        (prio),
        .ie_i          (ie),
        .thold_i       (thold),
        .claim_i       (claim),
        .complete_i    (complete),
        .complete_id_i (cid),
        .ip_o          (ip),
        .claim_id_o    (claim_id),
        .ext_irq_o     (ext_irq)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [IRQ_NUM-1:0] b(input int n);
        logic [IRQ_NUM-1:0] one;
        one = 1;
        return one << n;
    endfunction

    typedef struct {
        logic [IRQ_NUM-1:0]  src;
        logic [IRQ_NUM-1:0]  ie;
        logic [PRIO_WID-1:0] thold;
        logic                claim;
        logic                comp;
        logic [IRQ_WID-1:0]  cid;
        logic [IRQ_NUM-1:0]  exp_ip;
        logic [IRQ_WID-1:0]  exp_id;
        logic                exp_ext;
    } vec_t;

    function automatic vec_t mk(input logic [IRQ_NUM-1:0] src, input logic [IRQ_NUM-1:0] ie_v,
                                input int th, input bit cl, input bit cp, input int id,
                                input logic [IRQ_NUM-1:0] e_ip, input int e_id, input bit e_ext);
        vec_t v;
        v.src = src; v.ie = ie_v; v.thold = PRIO_WID'(th); v.claim = cl; v.comp = cp;
        v.cid = IRQ_WID'(id); v.exp_ip = e_ip; v.exp_id = IRQ_WID'(e_id); v.exp_ext = e_ext;
        return v;
    endfunction

    // Behavioural reference: pending/in-flight sets plus the presented id.
    bit m_pend [IRQ_NUM];
    bit m_infl [IRQ_NUM];
    int m_id;
    bit m_ext;

    task automatic model_clear();
        for (int i = 0; i < IRQ_NUM; i++) begin
            m_pend[i] = 0;
            m_infl[i] = 0;
        end
        m_id  = 0;
        m_ext = 0;
    endtask

    task automatic model_edge();
        bit fire;
        int best_p, best_i, p, old_id;
        fire   = claim && m_ext;
        old_id = m_id;
        best_p = 0;
        best_i = 0;
        for (int i = 1; i < IRQ_NUM; i++) begin
            p = int'(prio[i*PRIO_WID +: PRIO_WID]);
            if (m_pend[i] && ie[i] && p > best_p) begin
                best_p = p;
                best_i = i;
            end
        end
        for (int i = 1; i < IRQ_NUM; i++) begin
            if (m_pend[i]) begin
                if (fire && old_id == i) begin
                    m_pend[i] = 0;
                    m_infl[i] = 1;
                end
            end else if (m_infl[i]) begin
                if (complete && int'(cid) == i) m_infl[i] = 0;
            end else if (irq_src[i]) begin
                m_pend[i] = 1;
            end
        end
        if (fire) begin
            m_ext = 0;
            m_id  = 0;
        end else begin
            m_ext = best_p > int'(thold);
            m_id  = m_ext ? best_i : 0;
        end
    endtask

    function automatic logic [IRQ_NUM-1:0] model_ip();
        logic [IRQ_NUM-1:0] v;
        v = '0;
        for (int i = 1; i < IRQ_NUM; i++) v[i] = m_pend[i];
        return v;
    endfunction

    vec_t vq[$];

    initial begin
        logic [IRQ_NUM-1:0] ie_all, ie_no6, pq;
        int infl_q[$];

        ie_all = '1;
        ie_no6 = ie_all & ~b(6);
        pq     = b(2) | b(5) | b(7);

        // src, ie, thold, claim, comp, cid | ip, id, ext
        vq.push_back(mk(b(3),   ie_all, 0, 0, 0, 0,  b(3),        0, 0));
        vq.push_back(mk('0,     ie_all, 0, 0, 0, 0,  b(3),        3, 1));
        vq.push_back(mk('0,     ie_all, 0, 1, 0, 0,  '0,          0, 0));
        vq.push_back(mk('0,     ie_all, 0, 0, 0, 0,  '0,          0, 0));
        vq.push_back(mk('0,     ie_all, 0, 0, 1, 3,  '0,          0, 0));
        vq.push_back(mk(pq,     ie_all, 0, 0, 0, 0,  pq,          0, 0));
        vq.push_back(mk('0,     ie_all, 0, 0, 0, 0,  pq,          5, 1));
        vq.push_back(mk('0,     ie_all, 0, 1, 0, 0,  b(2) | b(7), 0, 0));
        vq.push_back(mk('0,     ie_all, 0, 0, 0, 0,  b(2) | b(7), 7, 1));
        vq.push_back(mk('0,     ie_all, 0, 1, 0, 0,  b(2),        0, 0));
        vq.push_back(mk('0,     ie_all, 0, 0, 0, 0,  b(2),        2, 1));
        vq.push_back(mk('0,     ie_all, 0, 1, 0, 0,  '0,          0, 0));
        vq.push_back(mk('0,     ie_all, 0, 0, 1, 5,  '0,          0, 0));
        vq.push_back(mk('0,     ie_all, 0, 0, 1, 7,  '0,          0, 0));
        vq.push_back(mk('0,     ie_all, 0, 0, 1, 2,  '0,          0, 0));
        vq.push_back(mk(b(4),   ie_all, 0, 0, 0, 0,  b(4),        0, 0));
        vq.push_back(mk(b(4),   ie_all, 0, 0, 0, 0,  b(4),        4, 1));
        vq.push_back(mk(b(4),   ie_all, 0, 1, 0, 0,  '0,          0, 0));
        vq.push_back(mk(b(4),   ie_all, 0, 0, 0, 0,  '0,          0, 0));
        vq.push_back(mk(b(4),   ie_all, 0, 0, 1, 4,  '0,          0, 0));
        vq.push_back(mk(b(4),   ie_all, 0, 0, 0, 0,  b(4),        0, 0));
        vq.push_back(mk(b(4),   ie_all, 0, 0, 0, 0,  b(4),        4, 1));
        vq.push_back(mk('0,     ie_all, 0, 1, 0, 0,  '0,          0, 0));
        vq.push_back(mk('0,     ie_all, 0, 0, 1, 4,  '0,          0, 0));
        vq.push_back(mk(b(6),   ie_all, 5, 0, 0, 0,  b(6),        0, 0));
        vq.push_back(mk('0,     ie_all, 5, 0, 0, 0,  b(6),        0, 0));
        vq.push_back(mk('0,     ie_all, 4, 0, 0, 0,  b(6),        6, 1));
        vq.push_back(mk('0,     ie_no6, 4, 0, 0, 0,  b(6),        0, 0));
        vq.push_back(mk('0,     ie_no6, 4, 0, 1, 0,  b(6),        0, 0));
        vq.push_back(mk('0,     ie_no6, 4, 0, 1, 25, b(6),        0, 0));
        vq.push_back(mk('0,     ie_no6, 4, 0, 1, 6,  b(6),        0, 0));
        vq.push_back(mk('0,     ie_no6, 4, 1, 0, 0,  b(6),        0, 0));
        vq.push_back(mk('0,     ie_all, 4, 0, 0, 0,  b(6),        6, 1));

        prio = '0;
        prio[1*PRIO_WID +: PRIO_WID] = 4'd7;
        prio[2*PRIO_WID +: PRIO_WID] = 4'd3;
        prio[3*PRIO_WID +: PRIO_WID] = 4'd2;
        prio[4*PRIO_WID +: PRIO_WID] = 4'd1;
        prio[5*PRIO_WID +: PRIO_WID] = 4'd6;
        prio[6*PRIO_WID +: PRIO_WID] = 4'd5;
        prio[7*PRIO_WID +: PRIO_WID] = 4'd6;
        prio[9*PRIO_WID +: PRIO_WID] = 4'd2;

        rst_n = 1'b0; irq_src = '0; ie = '0; thold = '0;
        claim = 1'b0; complete = 1'b0; cid = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ip", 32'(ip), 0);
        chk("reset_id", 32'(claim_id), 0);
        chk("reset_ext", 32'(ext_irq), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vq[k]) begin
            @(negedge clk);
            irq_src = vq[k].src; ie = vq[k].ie; thold = vq[k].thold;
            claim = vq[k].claim; complete = vq[k].comp; cid = vq[k].cid;
            @(posedge clk);
            #1;
            chk($sformatf("row%0d_ip", k), 32'(ip), 32'(vq[k].exp_ip));
            chk($sformatf("row%0d_id", k), 32'(claim_id), 32'(vq[k].exp_id));
            chk($sformatf("row%0d_ext", k), 32'(ext_irq), 32'(vq[k].exp_ext));
        end

        // Mid-operation asynchronous reset: 1 in flight, 6 and 9 pending.
        @(negedge clk);
        irq_src = b(1) | b(9); ie = ie_all; thold = 4'd4;
        claim = 1'b0; complete = 1'b0; cid = '0;
        @(posedge clk); #1;
        chk("mid_ip_a", 32'(ip), 32'(b(1) | b(6) | b(9)));
        chk("mid_id_a", 32'(claim_id), 6);
        @(posedge clk); #1;
        chk("mid_id_b", 32'(claim_id), 1);
        chk("mid_ext_b", 32'(ext_irq), 1);
        @(negedge clk);
        claim = 1'b1;
        @(posedge clk); #1;
        chk("mid_ip_c", 32'(ip), 32'(b(6) | b(9)));
        chk("mid_id_c", 32'(claim_id), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_ip", 32'(ip), 0);
        chk("async_rst_id", 32'(claim_id), 0);
        chk("async_rst_ext", 32'(ext_irq), 0);
        @(negedge clk);
        claim = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("repend_ip", 32'(ip), 32'(b(1) | b(9)));
        chk("repend_ext", 32'(ext_irq), 0);
        @(posedge clk); #1;
        chk("repend_id", 32'(claim_id), 1);
        chk("repend_ext2", 32'(ext_irq), 1);

        // Randomized traffic against the model.
        @(negedge clk);
        rst_n = 1'b0; irq_src = '0; claim = 1'b0; complete = 1'b0; cid = '0;
        ie = '1; thold = '0;
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            irq_src = IRQ_NUM'($urandom) & IRQ_NUM'($urandom) & IRQ_NUM'($urandom);
            if ($urandom_range(0, 15) == 0) ie = IRQ_NUM'($urandom) | IRQ_NUM'($urandom);
            if ($urandom_range(0, 31) == 0 || c == 0) begin
                for (int i = 0; i < IRQ_NUM; i++) begin
                    prio[i*PRIO_WID +: PRIO_WID] =
                        ($urandom_range(0, 3) == 0) ? '0 : PRIO_WID'($urandom_range(1, 15));
                end
            end
            if ($urandom_range(0, 15) == 0)
                thold = ($urandom_range(0, 5) == 0) ? 4'hF : PRIO_WID'($urandom_range(0, 4));
            claim    = ($urandom_range(0, 2) == 0);
            complete = ($urandom_range(0, 2) == 0);
            infl_q.delete();
            for (int i = 1; i < IRQ_NUM; i++) if (m_infl[i]) infl_q.push_back(i);
            if (infl_q.size() > 0 && $urandom_range(0, 3) != 0)
                cid = IRQ_WID'(infl_q[$urandom_range(0, infl_q.size() - 1)]);
            else
                cid = IRQ_WID'($urandom_range(0, 31));
            model_edge();
            @(posedge clk); #1;
            chk($sformatf("rnd%0d_ip", c), 32'(ip), 32'(model_ip()));
            chk($sformatf("rnd%0d_id", c), 32'(claim_id), 32'(m_id));
            chk($sformatf("rnd%0d_ext", c), 32'(ext_irq), 32'(m_ext));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
